access_ctrl_fsm: RTL

- Parametrised access-control state machine for the smart-house configuration path.
- Gates user writes of a configuration word into the memory unit behind a password check against the system key.
- Adds several features: request synchroniser, confirm edge detection, retry counting with timed lockout, inactivity timeout, and a registered config output.
- Sits between the user-input front end and the configuration memory unit.

---
 rtl/access_ctrl_fsm_if.sv | 29 ++
 rtl/access_ctrl_fsm.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/access_ctrl_fsm_if.sv
// Bundle of user-side and memory-side signals around the access-control FSM.
// The master drives the user inputs and the stored key; the FSM is the slave.
interface access_ctrl_fsm_if #(
   parameter int KEY_W = 2,
   parameter int CFG_W = 35
) ();

   logic             request;
   logic             confirm;
   logic [KEY_W-1:0] password;
   logic [KEY_W-1:0] syskey;
   logic [CFG_W-1:0] configin;
   logic [CFG_W-1:0] configout;
   logic             write_en;
   logic             locked;
   logic [3:0]       fail_cnt;
   logic [2:0]       dbg_state;

   modport master (
      output request, confirm, password, syskey, configin,
      input  configout, write_en, locked, fail_cnt, dbg_state
   );

   modport slave (
      input  request, confirm, password, syskey, configin,
      output configout, write_en, locked, fail_cnt, dbg_state
   );

endinterface

// File: rtl/access_ctrl_fsm.sv
// Access-control state machine for the smart-house configuration path.
// Writes of a configuration word to the memory unit are allowed only after the
// user password matches the system key. Repeated wrong passwords lock the path
// out for a fixed time; inactivity in ACTIVE/REQUEST returns the machine to IDLE.
module access_ctrl_fsm #(
   parameter int KEY_W          = 2,
   parameter int CFG_W          = 35,
   parameter int MAX_TRIES      = 3,
   parameter int LOCK_CYCLES    = 1024,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic               clk,
   input logic               arst,
   access_ctrl_fsm_if.slave  bus
);

   localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int LCK_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCK_CYCLES - 1);
   localparam logic [3:0]       TRIES    = 4'(MAX_TRIES);

   typedef enum logic [2:0] {
      IDLE    = 3'b001,
      ACTIVE  = 3'b010,
      REQUEST = 3'b011,
      STORE   = 3'b100,
      LOCKOUT = 3'b101
   } state_t;

   state_t           state;
   logic             req_q1;
   logic             req_s;
   logic             confirm_q;
   logic [TMR_W-1:0] tmr;
   logic [LCK_W-1:0] lck_cnt;

   logic [KEY_W-1:0] pw;
   logic [KEY_W-1:0] key;
   logic             conf_p;
   logic             passed;
   logic             tmr_done;
   logic             lck_done;
   logic [3:0]       fail_next;

   assign pw        = bus.password;
   assign key       = bus.syskey;
   assign passed    = (pw == key);
   assign conf_p    = bus.confirm & ~confirm_q;
   assign tmr_done  = (tmr == TMR_LAST);
   assign lck_done  = (lck_cnt == LCK_LAST);
   assign fail_next = bus.fail_cnt + 4'd1;

   assign bus.dbg_state = state;

   // Two-flop synchroniser for request and edge-detect register for confirm.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         req_q1    <= 1'b0;
         req_s     <= 1'b0;
         confirm_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let req_s take the old req_q1, forming a true two-stage chain.
         req_q1    <= bus.request;
         req_s     <= req_q1;
         confirm_q <= bus.confirm;
      end
   end

   // State register, timers and all registered outputs.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state         <= IDLE;
         tmr           <= '0;
         lck_cnt       <= '0;
         bus.write_en  <= 1'b0;
         bus.configout <= {CFG_W{1'b0}};
         bus.locked    <= 1'b0;
         bus.fail_cnt  <= 4'd0;
      end else begin
         // Strobe is high only on the cycle right after the STORE entry edge.
         bus.write_en <= 1'b0;
         case (state)
            IDLE: begin
               tmr <= '0;
               if (req_s) state <= ACTIVE;
            end
            ACTIVE: begin
               if (!req_s) begin
                  state <= IDLE;
               end else if (conf_p && passed) begin
                  state        <= REQUEST;
                  bus.fail_cnt <= 4'd0;
                  tmr          <= '0;
               end else if (conf_p) begin
                  bus.fail_cnt <= fail_next;
                  tmr          <= '0;
                  if (fail_next == TRIES) begin
                     state      <= LOCKOUT;
                     bus.locked <= 1'b1;
                     lck_cnt    <= '0;
                  end
               end else if (tmr_done) begin
                  state <= IDLE;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            REQUEST: begin
               if (!req_s) begin
                  state <= IDLE;
               end else if (conf_p) begin
                  state         <= STORE;
                  bus.write_en  <= 1'b1;
                  bus.configout <= bus.configin;
               end else if (tmr_done) begin
                  state <= IDLE;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            STORE: begin
               if (!req_s) state <= IDLE;
            end
            LOCKOUT: begin
               if (lck_done) begin
                  state        <= IDLE;
                  bus.locked   <= 1'b0;
                  bus.fail_cnt <= 4'd0;
                  lck_cnt      <= '0;
               end else begin
                  lck_cnt <= lck_cnt + 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               bus.locked <= 1'b0;
            end
         endcase
      end
   end

endmodule
